mcparc_mem_arbiter: RTL and testbench

Two-to-one memory request arbiter placed between the multicycle PARC core's instruction and data memory ports and a single-port test memory. It merges imem and dmem request streams onto one val/rdy request channel with round-robin arbitration. It records the source of every issued request in an in-order tag queue and routes each returning response to the port that issued it. Latency on both paths is zero cycles, so the arbiter adds no latency to a zero-delay memory.

---
 rtl/mcparc_mem_arbiter.sv | 111 +++++++++++
 tb/tb_mcparc_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcparc_mem_arbiter.sv
// Round-robin 2:1 merge of imem/dmem request streams onto one memory port, with
// in-order tag queue routing responses back to the issuing port; zero-latency both ways.
module mcparc_mem_arbiter #(
   parameter int p_req_sz  = 67,
   parameter int p_resp_sz = 35,
   parameter int p_max_out = 4
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic [p_req_sz-1:0]          req0_msg,
   input  logic                         req0_val,
   output logic                         req0_rdy,

   input  logic [p_req_sz-1:0]          req1_msg,
   input  logic                         req1_val,
   output logic                         req1_rdy,

   output logic [p_resp_sz-1:0]         resp0_msg,
   output logic                         resp0_val,
   input  logic                         resp0_rdy,

   output logic [p_resp_sz-1:0]         resp1_msg,
   output logic                         resp1_val,
   input  logic                         resp1_rdy,

   output logic [p_req_sz-1:0]          memreq_msg,
   output logic                         memreq_val,
   input  logic                         memreq_rdy,

   input  logic [p_resp_sz-1:0]         memresp_msg,
   input  logic                         memresp_val,
   output logic                         memresp_rdy,

   output logic [$clog2(p_max_out):0]   outstanding,
   output logic                         err
);

   localparam int c_ptr_w = $clog2(p_max_out);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(p_max_out);

   logic                 last;
   logic [p_max_out-1:0] tags;
   logic [c_ptr_w-1:0]   wr_ptr;
   logic [c_ptr_w-1:0]   rd_ptr;
   logic [c_cnt_w-1:0]   count;

   logic full;
   logic empty;
   logic any_val;
   logic sel;
   logic push;
   logic pop;
   logic head;

   assign full    = (count == c_max);
   assign empty   = (count == '0);
   assign any_val = req0_val | req1_val;

   // On a tie the port that did not win last time goes; otherwise whoever is valid.
   assign sel = (req0_val & req1_val) ? ~last : req1_val;

   // Gating with reset keeps every request-side valid low while reset is held.
   assign memreq_val = reset & any_val & ~full;
   assign memreq_msg = sel ? req1_msg : req0_msg;
   assign req0_rdy   = memreq_val & ~sel & memreq_rdy;
   assign req1_rdy   = memreq_val &  sel & memreq_rdy;
   assign push       = memreq_val & memreq_rdy;

   // Response steering uses only registered queue state (head tag, empty).
   assign head        = tags[rd_ptr];
   assign resp0_msg   = memresp_msg;
   assign resp1_msg   = memresp_msg;
   assign resp0_val   = ~empty & ~head & memresp_val;
   assign resp1_val   = ~empty &  head & memresp_val;
   assign memresp_rdy = empty | (head ? resp1_rdy : resp0_rdy);
   assign pop         = memresp_val & memresp_rdy & ~empty;

   assign outstanding = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last   <= 1'b1;
         tags   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         if (push) begin
            tags[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + c_ptr_w'(1);
            last         <= sel;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + c_ptr_w'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + c_cnt_w'(1);
            2'b01:   count <= count - c_cnt_w'(1);
            default: count <= count;
         endcase
         // A response with nothing outstanding is swallowed and flagged until reset.
         if (memresp_val && empty) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mcparc_mem_arbiter.sv
// Directed bench for mcparc_mem_arbiter: one-cycle memory model plus response scoreboard.
module tb_mcparc_mem_arbiter;

   typedef struct packed {
      logic        port;
      logic [34:0] msg;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [66:0] req0_msg, req1_msg, memreq_msg;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [34:0] resp0_msg, resp1_msg, memresp_msg;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
   logic [2:0]  outstanding;
   logic        err;

   logic [31:0] addr0, addr1;
   logic        exp_last, exp_err, mem_en, spur, resp0_seen;
   sb_t         sb_q[$];
   logic [34:0] mem_q[$];
   logic        gnt_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   function automatic logic [66:0] mkreq(input logic [31:0] a);
      return {1'b0, a, 2'b00, 32'h0};
   endfunction

   function automatic logic [34:0] mkresp(input logic [31:0] a);
      return {3'b000, a + 32'd1};
   endfunction

   assign req0_msg = mkreq(addr0);
   assign req1_msg = mkreq(addr1);

   mcparc_mem_arbiter #(.p_req_sz(67), .p_resp_sz(35), .p_max_out(4)) dut (
      .clk(clk), .reset(reset),
      .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
      .outstanding(outstanding), .err(err)
   );

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_mem();
      memresp_val = spur || (mem_en && mem_q.size() != 0);
      memresp_msg = (mem_q.size() != 0) ? mem_q[0] : 35'h0_1234_5678;
   endtask

   // One clock: check outputs at the falling edge, then update models after the rising edge.
   task automatic cyc();
      logic        go, sel, do_push, do_pop, mem_fire, h, set_err;
      logic [34:0] mresp;
      mresp   = '0;
      do_pop  = 1'b0;
      set_err = 1'b0;
      @(negedge clk);
      chk("outstanding", outstanding, sb_q.size());
      chk("err", err, exp_err);
      go  = reset && (req0_val || req1_val) && (sb_q.size() != 4);
      sel = (req0_val && req1_val) ? !exp_last : req1_val;
      chk("memreq_val", memreq_val, go);
      do_push = go && memreq_rdy;
      chk("req0_rdy", req0_rdy, do_push && !sel);
      chk("req1_rdy", req1_rdy, do_push && sel);
      if (go) chk("memreq_msg", memreq_msg, sel ? req1_msg : req0_msg);
      if (do_push) begin
         gnt_q.push_back(req1_rdy);
         mresp = mkresp(memreq_msg[65:34]);
      end
      mem_fire = memresp_val && memresp_rdy;
      if (sb_q.size() == 0) begin
         chk("memresp_rdy_empty", memresp_rdy, 1);
         chk("resp0_val_empty", resp0_val, 0);
         chk("resp1_val_empty", resp1_val, 0);
         if (memresp_val && reset) set_err = 1'b1;
      end else begin
         h = sb_q[0].port;
         chk("memresp_rdy", memresp_rdy, h ? resp1_rdy : resp0_rdy);
         chk("resp0_val", resp0_val, memresp_val && !h);
         chk("resp1_val", resp1_val, memresp_val && h);
         if (memresp_val && memresp_rdy) begin
            do_pop = 1'b1;
            chk("resp_msg", h ? resp1_msg : resp0_msg, sb_q[0].msg);
         end
      end
      if (resp0_val) resp0_seen = 1'b1;
      @(posedge clk);
      #1;
      if (mem_fire && mem_q.size() != 0) void'(mem_q.pop_front());
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) begin
         sb_q.push_back('{port: sel, msg: mkresp(sel ? addr1 : addr0)});
         mem_q.push_back(mresp);
         exp_last = sel;
         if (sel) addr1++;
         else     addr0++;
      end
      if (set_err) exp_err = 1'b1;
      drive_mem();
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && sb_q.size() != 0; i++) cyc();
      chk("drained", outstanding, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;  req0_val = 1'b1;  req1_val = 1'b1;
      addr0 = 32'h1000;  addr1 = 32'h2000;
      memreq_rdy = 1'b1;  resp0_rdy = 1'b1;  resp1_rdy = 1'b1;
      mem_en = 1'b1;  spur = 1'b0;  exp_last = 1'b1;  exp_err = 1'b0;  resp0_seen = 1'b0;
      drive_mem();

      // Reset held two cycles with both requesters valid.
      cyc();
      cyc();
      reset = 1'b1;

      // Contention: grants alternate starting with port 0.
      gnt_q.delete();
      repeat (8) cyc();
      chk("contention_count", gnt_q.size(), 8);
      foreach (gnt_q[i]) chk($sformatf("contention_grant%0d", i), gnt_q[i], i % 2);
      req0_val = 1'b0;  req1_val = 1'b0;
      drain();

      // Port 1 alone.
      gnt_q.delete();  resp0_seen = 1'b0;  req1_val = 1'b1;
      repeat (6) cyc();
      req1_val = 1'b0;
      chk("single_count", gnt_q.size(), 6);
      foreach (gnt_q[i]) chk($sformatf("single_grant%0d", i), gnt_q[i], 1);
      drain();
      chk("single_resp0_never", resp0_seen, 0);

      // Full queue blocks grants; no bypass when a pop coincides.
      mem_en = 1'b0;  drive_mem();
      req0_val = 1'b1;  req1_val = 1'b1;
      repeat (4) cyc();
      chk("full_out", outstanding, 4);
      chk("full_rdy0", req0_rdy, 0);
      chk("full_rdy1", req1_rdy, 0);
      cyc();
      mem_en = 1'b1;  drive_mem();
      #1;
      chk("nobypass_rdy0", req0_rdy, 0);
      chk("nobypass_rdy1", req1_rdy, 0);
      chk("nobypass_memresp_rdy", memresp_rdy, 1);
      cyc();
      mem_en = 1'b0;  drive_mem();
      #1;
      chk("refill_out", outstanding, 3);
      chk("refill_rdy", req0_rdy | req1_rdy, 1);
      cyc();
      chk("refill_full", outstanding, 4);
      req0_val = 1'b0;  req1_val = 1'b0;
      mem_en = 1'b1;  drive_mem();
      drain();

      // Response backpressure on port 0.
      mem_en = 1'b0;  drive_mem();
      req0_val = 1'b1;
      cyc();
      req0_val = 1'b0;  resp0_rdy = 1'b0;
      mem_en = 1'b1;  drive_mem();
      repeat (3) begin
         cyc();
         chk("bp_hold", outstanding, 1);
         chk("bp_memresp_rdy", memresp_rdy, 0);
      end
      resp0_rdy = 1'b1;
      cyc();
      chk("bp_release", outstanding, 0);

      // Spurious response with an empty queue.
      spur = 1'b1;  drive_mem();
      #1;
      chk("spur_memresp_rdy", memresp_rdy, 1);
      chk("spur_resp0_val", resp0_val, 0);
      chk("spur_resp1_val", resp1_val, 0);
      cyc();
      spur = 1'b0;  drive_mem();
      chk("spur_err", err, 1);
      repeat (3) cyc();
      chk("spur_err_sticky", err, 1);

      // Reset mid-operation discards tags; late responses flag an error.
      mem_en = 1'b0;  drive_mem();
      req1_val = 1'b1;
      cyc();
      cyc();
      req1_val = 1'b0;
      chk("prerst_out", outstanding, 2);
      reset = 1'b0;
      #1;
      chk("rst_out", outstanding, 0);
      chk("rst_err", err, 0);
      sb_q.delete();  exp_last = 1'b1;  exp_err = 1'b0;
      cyc();
      reset = 1'b1;
      mem_en = 1'b1;  drive_mem();
      cyc();
      chk("postrst_err", err, 1);
      repeat (2) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
